// File: rtl/uart_rx_controller_if.sv
// Bus bundle between uart_rx_controller, its UartReceiver and the host register block.
// slave = controller view, master = the receiver/host side driving it.
interface uart_rx_controller_if #(
  parameter int unsigned CLOCK_DIVISOR_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH          = 16
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic                             cfgWrite;
  logic [CLOCK_DIVISOR_WIDTH+5:0]   cfgWord;
  logic [1:0]                       dataBits;
  logic                             hasParity;
  logic [1:0]                       parityMode;
  logic                             extraStopBit;
  logic [CLOCK_DIVISOR_WIDTH-1:0]   clockDivisor;
  logic [8:0]                       rxDataOut;
  logic                             rxDataReceived;
  logic                             rxParityError;
  logic                             rxOverflow;
  logic                             rxBreak;
  logic                             receiveData;
  logic                             popReq;
  logic [9:0]                       popData;
  logic                             popValid;
  logic [CW-1:0]                    fifoCount;
  logic                             statusClear;
  logic                             errEnable;
  logic                             stickyParity;
  logic                             stickyOverrun;
  logic                             stickyBreak;
  logic                             stickyFifoOverrun;
  logic                             timeout;
  logic                             irq;

  modport slave (
    input  cfgWrite, cfgWord, rxDataOut, rxDataReceived, rxParityError, rxOverflow, rxBreak,
           popReq, statusClear, errEnable,
    output dataBits, hasParity, parityMode, extraStopBit, clockDivisor, receiveData,
           popData, popValid, fifoCount, stickyParity, stickyOverrun, stickyBreak,
           stickyFifoOverrun, timeout, irq
  );

  modport master (
    output cfgWrite, cfgWord, rxDataOut, rxDataReceived, rxParityError, rxOverflow, rxBreak,
           popReq, statusClear, errEnable,
    input  dataBits, hasParity, parityMode, extraStopBit, clockDivisor, receiveData,
           popData, popValid, fifoCount, stickyParity, stickyOverrun, stickyBreak,
           stickyFifoOverrun, timeout, irq
  );
endinterface

// File: rtl/uart_rx_controller.sv
// Host-side sequencer for one UART receiver: line config, RX FIFO, ack pulse,
// sticky error status, character timeout and a level interrupt.
module uart_rx_controller #(
  parameter int unsigned CLOCK_DIVISOR_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH          = 16,
  parameter int unsigned RX_THRESHOLD        = 8,
  parameter int unsigned TIMEOUT_BITS        = 40
) (
  input logic                 clk,
  input logic                 rst,
  uart_rx_controller_if.slave bus
);
  localparam int unsigned W  = CLOCK_DIVISOR_WIDTH;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(TIMEOUT_BITS + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, BREAK_ACK, WAIT_CLR} state_t;

  state_t        r_state, w_state_nxt;
  logic          w_push, w_brk, w_pop, w_full, w_wr, w_drop, w_to_clr, w_presc_tc;
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W:0]    r_presc;
  logic [BW-1:0] r_bit_cnt, w_bit_nxt;
  logic [1:0]    r_data_bits, r_parity_mode;
  logic          r_has_parity, r_extra_stop;
  logic [W-1:0]  r_clk_div;
  logic          r_receive_data, r_pop_valid, r_timeout, r_irq;
  logic [9:0]    r_pop_data;
  logic          r_st_parity, r_st_overrun, r_st_break, r_st_fifo_ovr;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Capture wins over break; WAIT_CLR holds until the receiver drops both flags.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_brk       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.rxDataReceived) w_state_nxt = CAPTURE;
        else if (bus.rxBreak)   w_state_nxt = BREAK_ACK;
      end
      CAPTURE: begin
        w_push      = 1'b1;
        w_state_nxt = WAIT_CLR;
      end
      BREAK_ACK: begin
        w_brk       = 1'b1;
        w_state_nxt = WAIT_CLR;
      end
      WAIT_CLR: if (!bus.rxDataReceived && !bus.rxBreak) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_pop      = bus.popReq && (r_count != '0);
  assign w_wr       = w_push && (!w_full || w_pop);
  assign w_drop     = w_push && w_full && !w_pop;
  assign w_to_clr   = w_push || w_pop || (r_count == '0);
  assign w_presc_tc = (r_presc == {r_clk_div, 1'b1});

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {bus.rxParityError, bus.rxDataOut};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_valid <= 1'b0;
      r_pop_data  <= '0;
    end else begin
      r_pop_valid <= w_pop;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_pop_data <= r_mem[r_rd_ptr];
      end
      if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Bit-time counter saturates at TIMEOUT_BITS; timeout rises on that edge.
  always_comb begin
    w_bit_nxt = r_bit_cnt;
    if (w_presc_tc && (r_bit_cnt != BW'(TIMEOUT_BITS))) w_bit_nxt = r_bit_cnt + BW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst || w_to_clr) begin
      r_presc   <= '0;
      r_bit_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_presc   <= w_presc_tc ? '0 : r_presc + (W+1)'(1);
      r_bit_cnt <= w_bit_nxt;
      r_timeout <= (w_bit_nxt == BW'(TIMEOUT_BITS));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data_bits    <= '0;
      r_has_parity   <= 1'b0;
      r_parity_mode  <= '0;
      r_extra_stop   <= 1'b0;
      r_clk_div      <= '0;
      r_receive_data <= 1'b0;
      r_st_parity    <= 1'b0;
      r_st_overrun   <= 1'b0;
      r_st_break     <= 1'b0;
      r_st_fifo_ovr  <= 1'b0;
      r_irq          <= 1'b0;
    end else begin
      if (bus.cfgWrite) begin
        r_data_bits   <= bus.cfgWord[1:0];
        r_has_parity  <= bus.cfgWord[2];
        r_parity_mode <= bus.cfgWord[4:3];
        r_extra_stop  <= bus.cfgWord[5];
        r_clk_div     <= bus.cfgWord[W+5:6];
      end
      r_receive_data <= (w_state_nxt == CAPTURE) || (w_state_nxt == BREAK_ACK);
      // A set event in the same cycle as statusClear takes precedence.
      r_st_parity   <= (w_push && bus.rxParityError) || (r_st_parity   && !bus.statusClear);
      r_st_overrun  <= (w_push && bus.rxOverflow)    || (r_st_overrun  && !bus.statusClear);
      r_st_break    <= w_brk                         || (r_st_break    && !bus.statusClear);
      r_st_fifo_ovr <= w_drop                        || (r_st_fifo_ovr && !bus.statusClear);
      r_irq <= (r_count >= CW'(RX_THRESHOLD)) || r_timeout ||
               (bus.errEnable && (r_st_parity || r_st_overrun || r_st_break || r_st_fifo_ovr));
    end
  end

  assign bus.dataBits          = r_data_bits;
  assign bus.hasParity         = r_has_parity;
  assign bus.parityMode        = r_parity_mode;
  assign bus.extraStopBit      = r_extra_stop;
  assign bus.clockDivisor      = r_clk_div;
  assign bus.receiveData       = r_receive_data;
  assign bus.popData           = r_pop_data;
  assign bus.popValid          = r_pop_valid;
  assign bus.fifoCount         = r_count;
  assign bus.stickyParity      = r_st_parity;
  assign bus.stickyOverrun     = r_st_overrun;
  assign bus.stickyBreak       = r_st_break;
  assign bus.stickyFifoOverrun = r_st_fifo_ovr;
  assign bus.timeout           = r_timeout;
  assign bus.irq               = r_irq;
endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed self-checking bench for uart_rx_controller with default parameters.
module tb_uart_rx_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_rx_controller_if #(.CLOCK_DIVISOR_WIDTH(24), .FIFO_DEPTH(16)) bus ();

  uart_rx_controller #(
    .CLOCK_DIVISOR_WIDTH(24), .FIFO_DEPTH(16), .RX_THRESHOLD(8), .TIMEOUT_BITS(40)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one character; ack is seen after the first edge, the push lands on the second.
  task automatic send_char(input logic [8:0] d, input logic perr, input logic ovf);
    bus.rxDataOut      = d;
    bus.rxParityError  = perr;
    bus.rxOverflow     = ovf;
    bus.rxDataReceived = 1'b1;
    tick();
    bus.rxDataReceived = 1'b0;
    tick();
    bus.rxParityError  = 1'b0;
    bus.rxOverflow     = 1'b0;
    tick();
  endtask

  logic [8:0] vals [17];

  initial begin
    bus.cfgWrite = 0; bus.cfgWord = '0; bus.rxDataOut = '0; bus.rxDataReceived = 0;
    bus.rxParityError = 0; bus.rxOverflow = 0; bus.rxBreak = 0; bus.popReq = 0;
    bus.statusClear = 0; bus.errEnable = 0;
    repeat (3) tick();
    chk("rst_count", 32'(bus.fifoCount), 0);
    chk("rst_ack", 32'(bus.receiveData), 0);
    chk("rst_irq", 32'(bus.irq), 0);
    rst = 1'b1;

    // 8N1, divisor 3: cfgWord = (3 << 6) | 2'b11
    bus.cfgWord = 30'h0C3; bus.cfgWrite = 1; tick(); bus.cfgWrite = 0;
    chk("cfg_bits", 32'(bus.dataBits), 3);
    chk("cfg_div", 32'(bus.clockDivisor), 3);

    // Single 0x55 character
    bus.rxDataOut = 9'h055; bus.rxDataReceived = 1; tick();
    chk("ack_pulse", 32'(bus.receiveData), 1);
    chk("cnt_before_push", 32'(bus.fifoCount), 0);
    bus.rxDataReceived = 0; tick();
    chk("ack_end", 32'(bus.receiveData), 0);
    chk("cnt_one", 32'(bus.fifoCount), 1);
    tick();
    bus.popReq = 1; tick(); bus.popReq = 0;
    chk("pop55_valid", 32'(bus.popValid), 1);
    chk("pop55_data", 32'(bus.popData), 32'h055);
    chk("pop55_cnt", 32'(bus.fifoCount), 0);
    tick();
    chk("pop_valid_1cyc", 32'(bus.popValid), 0);

    // Parity error char and error interrupt
    bus.errEnable = 1;
    send_char(9'h1A3, 1'b1, 1'b0);
    chk("st_parity", 32'(bus.stickyParity), 1);
    chk("irq_err", 32'(bus.irq), 1);
    bus.popReq = 1; tick(); bus.popReq = 0;
    chk("pop_perr", 32'(bus.popData), 32'h3A3);
    bus.statusClear = 1; tick(); bus.statusClear = 0;
    chk("st_parity_clr", 32'(bus.stickyParity), 0);
    tick();
    chk("irq_clr", 32'(bus.irq), 0);
    bus.errEnable = 0;

    // Overflow sticky
    send_char(9'h011, 1'b0, 1'b1);
    chk("st_overrun", 32'(bus.stickyOverrun), 1);
    bus.popReq = 1; tick(); bus.popReq = 0;
    bus.statusClear = 1; tick(); bus.statusClear = 0;

    // 17 chars into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      vals[i] = 9'(i * 7 + 1);
      send_char(vals[i], 1'b0, 1'b0);
    end
    chk("full_cnt", 32'(bus.fifoCount), 16);
    chk("st_fifo_ovr", 32'(bus.stickyFifoOverrun), 1);
    chk("irq_thresh", 32'(bus.irq), 1);
    bus.statusClear = 1; tick(); bus.statusClear = 0;

    // Push and pop in the same cycle while full
    bus.rxDataOut = 9'h0AA; bus.rxDataReceived = 1; tick();
    bus.rxDataReceived = 0; bus.popReq = 1; tick(); bus.popReq = 0;
    chk("pp_valid", 32'(bus.popValid), 1);
    chk("pp_data", 32'(bus.popData), 32'(vals[0]));
    chk("pp_cnt", 32'(bus.fifoCount), 16);
    chk("pp_no_ovr", 32'(bus.stickyFifoOverrun), 0);
    tick();
    for (int k = 1; k < 17; k++) begin
      bus.popReq = 1; tick();
      chk($sformatf("drain%0d", k), 32'(bus.popData), (k < 16) ? 32'(vals[k]) : 32'h0AA);
    end
    tick();
    bus.popReq = 0;
    chk("pop_empty", 32'(bus.popValid), 0);
    chk("empty_cnt", 32'(bus.fifoCount), 0);

    // Timeout: bit time 8 clocks, 40 bits -> 320 clocks after the push edge
    send_char(9'h041, 1'b0, 1'b0);
    repeat (318) tick();
    chk("to_early", 32'(bus.timeout), 0);
    tick();
    chk("to_set", 32'(bus.timeout), 1);
    tick();
    chk("to_irq", 32'(bus.irq), 1);
    bus.popReq = 1; tick(); bus.popReq = 0;
    chk("to_pop_clr", 32'(bus.timeout), 0);
    chk("to_pop_data", 32'(bus.popData), 32'h041);

    // Break, then reset while waiting for the receiver to clear
    tick();
    bus.rxBreak = 1; tick();
    chk("brk_ack", 32'(bus.receiveData), 1);
    tick();
    chk("st_break", 32'(bus.stickyBreak), 1);
    chk("brk_no_push", 32'(bus.fifoCount), 0);
    tick();
    chk("brk_single_ack", 32'(bus.receiveData), 0);
    rst = 0; tick();
    chk("rst2_break", 32'(bus.stickyBreak), 0);
    chk("rst2_div", 32'(bus.clockDivisor), 0);
    chk("rst2_bits", 32'(bus.dataBits), 0);
    chk("rst2_ack", 32'(bus.receiveData), 0);
    bus.rxBreak = 0; rst = 1; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
